mc_control: RTL and testbench

//  Multicycle control FSM for the 16-bit datapath built around the 8x16 register file (r0 hardwired to 0,

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 35 +++
 rtl/mc_control.sv | 178 +++++++++++++++++
 tb/tb_mc_control.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: definitions shared by the multicycle control FSM, the datapath and
// the ALU of the 16-bit machine.
//   - state_t     : control FSM state encoding
//   - OP_*        : opcode values carried in IR[15:12]
//   - ALU_*       : ALU operation select codes (R-type funct maps straight onto these)
//   - PC_SRC_*    : PC input mux selects
//   - SRC_B_*     : ALU B-operand mux selects
//   - iclass_t    : instruction-class flags produced by mc_decode
package mc_pkg;

    localparam int OP_W    = 4;
    localparam int ALUOP_W = 3;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_LW    = 4'h2;
    localparam logic [OP_W-1:0] OP_SW    = 4'h3;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OP_W-1:0] OP_J     = 4'h5;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 3'd7;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;  // PC + 2 straight from the ALU
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;  // branch target latched in ALUOut
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;  // jump target

    localparam logic [1:0] SRC_B_RD2     = 2'd0;
    localparam logic [1:0] SRC_B_TWO     = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;  // sign-extended imm6
    localparam logic [1:0] SRC_B_IMM_SH1 = 2'd3;  // sign-extended imm6 << 1

    typedef struct packed {
        logic is_rtype;
        logic is_addi;
        logic is_ld;
        logic is_st;
        logic is_mem;
        logic is_beq;
        logic is_jmp;
        logic is_halt;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode -> instruction-class flags.
// Ports:
//   opcode  in  OPW       IR[15:12]
//   cls     out iclass_t  one-hot-ish class flags; is_mem covers both LW and SW,
//                         illegal is set for every opcode outside the defined set
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPW = OP_W
) (
    input  logic [OPW-1:0] opcode,
    output iclass_t        cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: cls.is_rtype = 1'b1;
            OP_ADDI:  cls.is_addi  = 1'b1;
            OP_LW: begin
                cls.is_ld  = 1'b1;
                cls.is_mem = 1'b1;
            end
            OP_SW: begin
                cls.is_st  = 1'b1;
                cls.is_mem = 1'b1;
            end
            OP_BEQ:   cls.is_beq   = 1'b1;
            OP_J:     cls.is_jmp   = 1'b1;
            OP_HALT:  cls.is_halt  = 1'b1;
            default:  cls.illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for the 16-bit datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus absorbing HALT) and drives every
// datapath enable and mux select.
//
// Optional feature macro: MC_SINGLE_STEP_EN
//   defined   - FETCH idles with mem_req=0 until step=1 is sampled, then one
//               full instruction runs; step held high runs continuously.
//   undefined - free-running, step is ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   opcode, funct     IR[15:12] and IR[2:0]
//   zero              ALU zero flag, used by BEQ in EXEC
//   mem_ready         memory finishes the current access this cycle
//   step              single-step advance (feature build only)
//   mem_req, mem_we, iord               memory request / store / address select
//   ir_write, pc_write, pc_src          IR and PC load controls
//   reg_write, reg_dst, mem_to_reg      register file write controls
//   alu_src_a, alu_src_b, alu_op        ALU operand selects and operation
//   halted            sticky after HALT until rst
//   illegal           one-cycle pulse in DECODE for an undefined opcode
//   dbg_state         current FSM state
//
// Handshake: mem_req rises in FETCH/MEM and stays high with all other outputs
// unchanged until a cycle in which mem_ready=1; that cycle completes the access.
// mem_ready is ignored whenever mem_req=0.
module mc_control
    import mc_pkg::*;
#(
    parameter int OPW    = OP_W,
    parameter int ALUOPW = ALUOP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [2:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    input  logic              step,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic              halted,
    output logic              illegal,
    output state_t            dbg_state
);

    state_t  state;
    iclass_t cls;

    // fetch_en gates the FETCH outputs. It is cleared by reset so that nothing
    // is requested while rst is high and the first mem_req appears only one
    // cycle after rst falls; in the single-step build it also holds the FSM
    // idle in FETCH until step is seen.
    logic fetch_en;

`ifndef MC_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    mc_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_en <= 1'b0;
        end else begin
`ifdef MC_SINGLE_STEP_EN
            // Re-sample step while an instruction is in flight and while idle;
            // once a fetch has started it must not be abandoned mid-handshake.
            if (state != FETCH || !fetch_en) begin
                fetch_en <= step;
            end
`else
            fetch_en <= 1'b1;
`endif
            case (state)
                FETCH: begin
                    if (fetch_en && mem_ready) state <= DECODE;
                end
                DECODE: begin
                    if (cls.is_halt)                  state <= HALT;
                    else if (cls.is_jmp || cls.illegal) state <= FETCH;
                    else                              state <= EXEC;
                end
                EXEC: begin
                    if (cls.is_mem)      state <= MEM;
                    else if (cls.is_beq) state <= FETCH;
                    else                 state <= WB;
                end
                MEM: begin
                    if (mem_ready) state <= cls.is_ld ? WB : FETCH;
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RD2;
        alu_op     = ALUOPW'(ALU_ADD);
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                if (fetch_en) begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_TWO;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            DECODE: begin
                // Branch target PC + (imm6 << 1) lands in ALUOut for BEQ.
                alu_src_b = SRC_B_IMM_SH1;
                illegal   = cls.illegal;
                if (cls.is_jmp) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (cls.is_rtype) begin
                    alu_op = ALUOPW'(funct);
                end else if (cls.is_beq) begin
                    alu_op   = ALUOPW'(ALU_SUB);
                    pc_write = zero;
                    pc_src   = PC_SRC_ALUOUT;
                end else if (cls.is_addi || cls.is_mem) begin
                    alu_src_b = SRC_B_IMM;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = cls.is_st;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.is_rtype;
                mem_to_reg = cls.is_ld;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control.
// Builds MC_SINGLE_STEP_EN-aware: the single-step sequence is compiled only
// when that macro is defined; otherwise step is driven randomly to show it
// has no effect.
module tb_mc_control;
    import mc_pkg::*;

`ifdef MC_SINGLE_STEP_EN
    localparam bit STEP_BUILD = 1'b1;
`else
    localparam bit STEP_BUILD = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero, mem_ready, step;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, halted, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    state_t     dbg_state;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .step(step), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
    } out_t;

    out_t act;
    assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal};

    // ---------------- scoreboard ----------------
    logic        rdy_q[$];
    logic        zero_q[$];
    logic [17:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_out(input string name, input int cyc, input logic [17:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs got %h expected %h", name, cyc, act, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [3:0] op);
        return (op <= 4'h5) || (op == 4'hF);
    endfunction

    // Instruction latency in cycles, zero-wait base plus one per wait cycle.
    function automatic int spec_len(input logic [3:0] op, input int wf, input int wm);
        case (op)
            4'h0, 4'h1: return 4 + wf;
            4'h2:       return 5 + wf + wm;
            4'h3:       return 4 + wf + wm;
            4'h4:       return 3 + wf;
            default:    return 2 + wf;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic z, input out_t o);
        rdy_q.push_back(r);
        zero_q.push_back(z);
        exp_q.push_back(18'(o));
    endtask

    // Expected per-cycle outputs for one instruction, with the mem_ready/zero
    // values to drive on each of those cycles.
    task automatic model_instr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                               input int wf, input int wm);
        out_t o;
        for (int i = 0; i <= wf; i++) begin
            o = '0;
            o.mem_req   = 1'b1;
            o.alu_src_b = 2'd1;
            o.alu_op    = ALU_ADD;
            if (i == wf) begin
                o.ir_write = 1'b1;
                o.pc_write = 1'b1;
            end
            push(i == wf, rbit(), o);
        end
        o = '0;
        o.alu_src_b = 2'd3;
        o.alu_op    = ALU_ADD;
        if (op == 4'h5) begin
            o.pc_write = 1'b1;
            o.pc_src   = 2'd2;
        end
        o.illegal = !is_legal(op);
        push(rbit(), rbit(), o);
        if (op == 4'h5 || op == 4'hF || !is_legal(op)) return;
        o = '0;
        o.alu_src_a = 1'b1;
        if (op == 4'h0) begin
            o.alu_op = fn;
        end else if (op == 4'h4) begin
            o.alu_op   = ALU_SUB;
            o.pc_write = z;
            o.pc_src   = 2'd1;
        end else begin
            o.alu_src_b = 2'd2;
            o.alu_op    = ALU_ADD;
        end
        push(rbit(), (op == 4'h4) ? z : rbit(), o);
        if (op == 4'h4) return;
        if (op == 4'h2 || op == 4'h3) begin
            for (int i = 0; i <= wm; i++) begin
                o = '0;
                o.mem_req = 1'b1;
                o.iord    = 1'b1;
                o.mem_we  = (op == 4'h3);
                push(i == wm, rbit(), o);
            end
        end
        if (op == 4'h3) return;
        o = '0;
        o.reg_write  = 1'b1;
        o.reg_dst    = (op == 4'h0);
        o.mem_to_reg = (op == 4'h2);
        push(rbit(), rbit(), o);
    endtask

    // ---------------- driver ----------------
    // step_mode: 0 = default for the build, 1 = force low.
    // Returns the cycle count until the FSM is back in FETCH (0 if never).
    task automatic run_trace(input string name, input int wf, input int max_cyc,
                             input int step_mode, output int done_at);
        logic r, z;
        logic [17:0] e;
        int k;
        k = 0;
        done_at = 0;
        while (exp_q.size() > 0 && k < max_cyc) begin
            r = rdy_q.pop_front();
            z = zero_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            mem_ready = r;
            zero      = z;
            if (step_mode == 1)  step = 1'b0;
            else if (STEP_BUILD) step = 1'b1;
            else                 step = rbit();
            #1;
            check_out(name, k, e);
            @(posedge clk);
            #1;
            k++;
            if (done_at == 0 && k > wf + 1 && dbg_state == FETCH) done_at = k;
        end
        rdy_q.delete();
        zero_q.delete();
        exp_q.delete();
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input logic [2:0] fn,
                             input logic z, input int wf, input int wm, input int step_mode);
        int done_at;
        opcode = op;
        funct  = fn;
        model_instr(op, fn, z, wf, wm);
        run_trace(name, wf, 1000, step_mode, done_at);
        check_int({name, "_len"}, done_at, spec_len(op, wf, wm));
    endtask

    task automatic idle_cycles(input string name, input int n, input int step_mode);
        out_t o;
        o = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = rbit();
            zero      = rbit();
            if (step_mode == 1) step = 1'b0;
            else                step = rbit();
            #1;
            check_out(name, i, 18'(o));
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] op;
        logic [2:0] fn;
        logic       z;
        int         wf;
        int         wm;
        int         len;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wf, wm;
        logic [3:0] op;
        out_t o;

        vecs[0]  = '{4'h1, 3'd0, 1'b0, 0, 0, 4};  // ADDI r1,r0,5
        vecs[1]  = '{4'h2, 3'd0, 1'b0, 0, 3, 8};  // LW, 3 wait cycles in MEM
        vecs[2]  = '{4'h4, 3'd0, 1'b1, 0, 0, 3};  // BEQ taken
        vecs[3]  = '{4'h4, 3'd0, 1'b0, 0, 0, 3};  // BEQ not taken
        vecs[4]  = '{4'h0, 3'd5, 1'b0, 2, 0, 6};  // RTYPE, slow fetch
        vecs[5]  = '{4'h3, 3'd0, 1'b0, 0, 1, 5};  // SW, one MEM wait
        vecs[6]  = '{4'h5, 3'd0, 1'b0, 0, 0, 2};  // J
        vecs[7]  = '{4'h5, 3'd0, 1'b0, 1, 0, 3};  // J, slow fetch
        vecs[8]  = '{4'h9, 3'd0, 1'b0, 0, 0, 2};  // illegal
        vecs[9]  = '{4'h6, 3'd0, 1'b0, 0, 0, 2};  // illegal, lowest undefined
        vecs[10] = '{4'hE, 3'd0, 1'b0, 0, 0, 2};  // illegal, highest undefined
        vecs[11] = '{4'h2, 3'd0, 1'b0, 0, 0, 5};  // LW zero wait

        rst = 1'b1; opcode = 4'h0; funct = 3'd0; zero = 1'b0;
        mem_ready = 1'b1; step = STEP_BUILD;

        // Reset state: everything low even with mem_ready high.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_out("reset_outputs", 0, 18'd0);
        check_int("reset_state", int'(dbg_state), int'(FETCH));
        rst = 1'b0;
        #1;
        check_out("first_cycle_after_rst", 0, 18'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            int done_at;
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            model_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].wf, vecs[i].wm);
            run_trace($sformatf("vec%0d", i), vecs[i].wf, 1000, 0, done_at);
            check_int($sformatf("vec%0d_len", i), done_at, vecs[i].len);
        end

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 8) op = 4'($urandom_range(0, 5));
            else                          op = 4'($urandom_range(6, 14));
            wf = $urandom_range(0, 2);
            wm = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), rbit(), wf, wm, 0);
        end

        // Reset in the middle of a MEM wait: request drops at once.
        begin
            int done_at;
            opcode = 4'h2;
            funct  = 3'd0;
            model_instr(4'h2, 3'd0, 1'b0, 0, 10);
            run_trace("lw_pre_reset", 0, 6, 0, done_at);
            #2;
            rst = 1'b1;
            #1;
            check_int("rst_mem_req_drop", int'(mem_req), 0);
            check_out("rst_mid_mem", 0, 18'd0);
            check_int("rst_mid_mem_state", int'(dbg_state), int'(FETCH));
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_out("after_mid_rst", 0, 18'd0);
            @(posedge clk); #1;
            run_instr("addi_after_rst", 4'h1, 3'd0, 1'b0, 0, 0, 0);
        end

        // HALT: absorbing, only halted set, whatever the inputs do.
        begin
            int done_at;
            opcode = 4'hF;
            model_instr(4'hF, 3'd0, 1'b0, 1, 0);
            run_trace("halt_entry", 1, 1000, 0, done_at);
            check_int("halt_state", int'(dbg_state), int'(HALT));
            o = '0;
            o.halted = 1'b1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                mem_ready = rbit();
                zero      = rbit();
                step      = rbit();
                opcode    = 4'($urandom_range(0, 15));
                #1;
                check_out("halted_hold", i, 18'(o));
            end
            @(negedge clk);
            rst = 1'b1;
            #1;
            check_out("halt_cleared", 0, 18'd0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            run_instr("addi_after_halt", 4'h1, 3'd0, 1'b0, 0, 0, 0);
        end

`ifdef MC_SINGLE_STEP_EN
        // Single step: idle with no request, one pulse runs exactly one RTYPE.
        @(negedge clk);
        step = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles("step_idle", 6, 1);
        @(negedge clk);
        step = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_int("step_pulse_no_req", int'(mem_req), 0);
        @(posedge clk); #1;
        run_instr("step_rtype", 4'h0, 3'd2, 1'b0, 0, 0, 1);
        idle_cycles("step_after", 10, 1);
`else
        idle_cycles("unused_idle_probe", 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
